// File: rtl/fifo_srl_param_pkg.sv
// Shared constants and helpers for the SRL-based FIFO family.
// Default geometry matches the 16-deep, 24-bit DSP sample buffer.
package fifo_srl_param_pkg;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_DEPTH = 16;

    // Ceiling log2 for sizing address and count fields at elaboration time.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        while ((32'sd1 << result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_srl_param_srl_array.sv
// WIDTH x DEPTH shift register with clock enable and a variable read tap.
// New words enter at index 0; the tap is read combinationally (SRL16/SRL32 style).
module fifo_srl_param_srl_array
    import fifo_srl_param_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2(DEF_DEPTH)
) (
    input  logic             clk,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Shift chain; deliberately unreset so it maps onto SRL primitives.
    always_ff @(posedge clk) begin
        if (ce) begin
            mem_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                mem_r[i] <= mem_r[i-1];
            end
        end
    end

    assign q = mem_r[addr];

endmodule

// File: rtl/fifo_srl_param.sv
// Parametrised SRL-based synchronous FIFO with registered output stage,
// fill count, almost-full/empty thresholds, flush and sticky error flags.
module fifo_srl_param
    import fifo_srl_param_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          pdi,
    input  logic                      iv,
    input  logic                      oe,
    output logic [WIDTH-1:0]          pdo,
    output logic                      ov,
    output logic                      empty,
    output logic                      full,
    output logic                      afull,
    output logic                      aempty,
    output logic [clog2(DEPTH):0]     count,
    output logic                      ovf,
    output logic                      udf
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ZERO_C  = {(AW+1){1'b0}};
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};

    logic             we_s;
    logic             rd_s;
    logic             ce_s;
    logic [AW-1:0]    raddr_s;
    logic [WIDTH-1:0] rdata_s;
    logic [AW:0]      count_nxt_s;

    logic [AW:0]      count_r;
    logic             empty_r;
    logic             full_r;
    logic             afull_r;
    logic             aempty_r;
    logic [WIDTH-1:0] pdo_r;
    logic             ov_r;
    logic             ovf_r;
    logic             udf_r;

    // Request qualification, next count and read tap (oldest word at count-1).
    always_comb begin
        we_s        = iv & ~full_r;
        rd_s        = oe & ~empty_r;
        ce_s        = we_s & rst & ~flush;
        // Low AW bits minus one also yields DEPTH-1 when count == DEPTH.
        raddr_s     = count_r[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
        count_nxt_s = count_r;
        case ({we_s, rd_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    fifo_srl_param_srl_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_srl (
        .clk  (clk),
        .ce   (ce_s),
        .d    (pdi),
        .addr (raddr_s),
        .q    (rdata_s)
    );

    // Count, flags derived from next count, output register and sticky errors.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r  <= ZERO_C;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
            pdo_r    <= {WIDTH{1'b0}};
            ov_r     <= 1'b0;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else if (flush) begin
            count_r  <= ZERO_C;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
            ov_r     <= 1'b0;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            count_r  <= count_nxt_s;
            empty_r  <= (count_nxt_s == ZERO_C);
            full_r   <= (count_nxt_s == DEPTH_C);
            afull_r  <= (count_nxt_s >= AF_C);
            aempty_r <= (count_nxt_s <= AE_C);
            ov_r     <= rd_s;
            if (rd_s) begin
                pdo_r <= rdata_s;
            end
            if (iv & full_r) begin
                ovf_r <= 1'b1;
            end
            if (oe & empty_r) begin
                udf_r <= 1'b1;
            end
        end
    end

    assign pdo    = pdo_r;
    assign ov     = ov_r;
    assign empty  = empty_r;
    assign full   = full_r;
    assign afull  = afull_r;
    assign aempty = aempty_r;
    assign count  = count_r;
    assign ovf    = ovf_r;
    assign udf    = udf_r;

endmodule

// File: tb/tb_fifo_srl_param.sv
// Bench for fifo_srl_param: two instances (24x16 and 8x32) driven by shared
// directed stimulus, checked every cycle against a queue-style model plus literals.
module tb_fifo_srl_param;

    logic        clk = 1'b0;
    logic        rst, flush, iv, oe;
    logic [23:0] pdi;

    logic [23:0] pdo_a;
    logic        ov_a, empty_a, full_a, afull_a, aempty_a, ovf_a, udf_a;
    logic [4:0]  count_a;
    logic [7:0]  pdo_b;
    logic        ov_b, empty_b, full_b, afull_b, aempty_b, ovf_b, udf_b;
    logic [5:0]  count_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_srl_param #(.WIDTH(24), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .pdi(pdi), .iv(iv), .oe(oe),
        .pdo(pdo_a), .ov(ov_a), .empty(empty_a), .full(full_a), .afull(afull_a),
        .aempty(aempty_a), .count(count_a), .ovf(ovf_a), .udf(udf_a));

    fifo_srl_param #(.WIDTH(8), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(1)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .pdi(pdi[7:0]), .iv(iv), .oe(oe),
        .pdo(pdo_b), .ov(ov_b), .empty(empty_b), .full(full_b), .afull(afull_b),
        .aempty(aempty_b), .count(count_b), .ovf(ovf_b), .udf(udf_b));

    // Model: element 0 is the oldest word, m_sz words are held.
    logic [63:0] m_mem [2][256];
    int          m_sz  [2];
    logic [63:0] m_pdo [2];
    logic        m_ov  [2];
    logic        m_ovf [2];
    logic        m_udf [2];
    bit          started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int k, input int depth, input logic [63:0] din);
        bit was_full;
        bit was_empty;
        was_full  = (m_sz[k] == depth);
        was_empty = (m_sz[k] == 0);
        if (!rst) begin
            m_sz[k] = 0; m_pdo[k] = 64'd0; m_ov[k] = 1'b0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
        end else if (flush) begin
            m_sz[k] = 0; m_ov[k] = 1'b0; m_ovf[k] = 1'b0; m_udf[k] = 1'b0;
        end else begin
            if (iv && was_full)  m_ovf[k] = 1'b1;
            if (oe && was_empty) m_udf[k] = 1'b1;
            if (oe && !was_empty) begin
                m_pdo[k] = m_mem[k][0];
                for (int i = 0; i < m_sz[k] - 1; i++) m_mem[k][i] = m_mem[k][i+1];
                m_sz[k]--;
                m_ov[k] = 1'b1;
            end else begin
                m_ov[k] = 1'b0;
            end
            if (iv && !was_full) begin
                m_mem[k][m_sz[k]] = din;
                m_sz[k]++;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 16, {40'd0, pdi});
        model_step(1, 32, {56'd0, pdi[7:0]});
        started = 1'b1;
    end

    task automatic compare_dut(input string p, input int k, input int depth, input int af,
                               input logic [63:0] pdo_v, input logic ov_v, input logic empty_v,
                               input logic full_v, input logic afull_v, input logic aempty_v,
                               input logic [63:0] count_v, input logic ovf_v, input logic udf_v);
        check({p, ".pdo"},    pdo_v,            m_pdo[k]);
        check({p, ".ov"},     {63'd0, ov_v},    {63'd0, m_ov[k]});
        check({p, ".count"},  count_v,          64'(m_sz[k]));
        check({p, ".empty"},  {63'd0, empty_v}, {63'd0, m_sz[k] == 0});
        check({p, ".full"},   {63'd0, full_v},  {63'd0, m_sz[k] == depth});
        check({p, ".afull"},  {63'd0, afull_v}, {63'd0, m_sz[k] >= af});
        check({p, ".aempty"}, {63'd0, aempty_v},{63'd0, m_sz[k] <= 1});
        check({p, ".ovf"},    {63'd0, ovf_v},   {63'd0, m_ovf[k]});
        check({p, ".udf"},    {63'd0, udf_v},   {63'd0, m_udf[k]});
    endtask

    // Per-cycle comparison on the falling edge, away from output updates.
    always @(negedge clk) begin
        if (started) begin
            compare_dut("a", 0, 16, 14, {40'd0, pdo_a}, ov_a, empty_a, full_a, afull_a,
                        aempty_a, {59'd0, count_a}, ovf_a, udf_a);
            compare_dut("b", 1, 32, 28, {56'd0, pdo_b}, ov_b, empty_b, full_b, afull_b,
                        aempty_b, {58'd0, count_b}, ovf_b, udf_b);
        end
    end

    task automatic cycle(input logic r, input logic f, input logic i, input logic o,
                         input logic [23:0] d);
        @(negedge clk);
        rst = r; flush = f; iv = i; oe = o; pdi = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; iv = 1'b0; oe = 1'b0; pdi = 24'd0;
        // 1: reset, fill 16 words
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
        check("t1.rst_count", {59'd0, count_a}, 64'd0);
        check("t1.rst_aempty", {63'd0, aempty_a}, 64'd1);
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'(i));
            if (i == 1)  check("t1.aempty_c1",  {63'd0, aempty_a}, 64'd1);
            if (i == 2)  check("t1.aempty_c2",  {63'd0, aempty_a}, 64'd0);
            if (i == 13) check("t1.afull_c13",  {63'd0, afull_a},  64'd0);
            if (i == 14) check("t1.afull_c14",  {63'd0, afull_a},  64'd1);
            if (i == 15) check("t1.full_c15",   {63'd0, full_a},   64'd0);
            if (i == 16) check("t1.full_c16",   {63'd0, full_a},   64'd1);
        end
        check("t1.count16", {59'd0, count_a}, 64'd16);
        // 2: drain with 17 reads
        for (int i = 1; i <= 17; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'd0);
            if (i <= 16) begin
                check("t2.pdo", {40'd0, pdo_a}, 64'(i));
                check("t2.ov",  {63'd0, ov_a},  64'd1);
            end else begin
                check("t2.ov17",    {63'd0, ov_a},    64'd0);
                check("t2.udf17",   {63'd0, udf_a},   64'd1);
                check("t2.empty17", {63'd0, empty_a}, 64'd1);
            end
        end
        // 3: steady count 5 with simultaneous read and write
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'h10 + 24'(i));
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b1, 24'h100 + 24'(i));
            check("t3.pdo", {40'd0, pdo_a}, (i < 5) ? 64'h10 + 64'(i) : 64'h100 + 64'(i - 5));
            check("t3.count", {59'd0, count_a}, 64'd5);
        end
        // 4: overflow while full, then drain past empty
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'h200 + 24'(i));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'hABCDEF);
        check("t4.ovf", {63'd0, ovf_a}, 64'd1);
        check("t4.count", {59'd0, count_a}, 64'd16);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        check("t4.ovf_sticky", {63'd0, ovf_a}, 64'd1);
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'd0);
            check("t4.no_dropped", {63'd0, pdo_a == 24'hABCDEF}, 64'd0);
            if (i == 0)  check("t4.first", {40'd0, pdo_a}, 64'h105);
            if (i == 15) check("t4.last",  {40'd0, pdo_a}, 64'h20A);
        end
        // 5: flush at count 9 with iv&oe, then reset mid-stream
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'h300 + 24'(i));
        check("t5.count9", {59'd0, count_a}, 64'd9);
        check("t5.udf_pre", {63'd0, udf_a}, 64'd1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 24'h3FF);
        check("t5.fl_count", {59'd0, count_a}, 64'd0);
        check("t5.fl_empty", {63'd0, empty_a}, 64'd1);
        check("t5.fl_ovf",   {63'd0, ovf_a},   64'd0);
        check("t5.fl_udf",   {63'd0, udf_a},   64'd0);
        check("t5.fl_ov",    {63'd0, ov_a},    64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'h400 + 24'(i));
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'd0);
        check("t5.pdo_pre", {40'd0, pdo_a}, 64'h400);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 24'h555);
        check("t5.rst_pdo",   {40'd0, pdo_a},   64'd0);
        check("t5.rst_count", {59'd0, count_a}, 64'd0);
        check("t5.rst_ov",    {63'd0, ov_a},    64'd0);
        // 6: 8x32 instance fill and drain
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'd0);
        for (int i = 1; i <= 32; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 24'(i));
            if (i == 27) check("t6.afull27", {63'd0, afull_b}, 64'd0);
            if (i == 28) check("t6.afull28", {63'd0, afull_b}, 64'd1);
            if (i == 31) check("t6.full31",  {63'd0, full_b},  64'd0);
            if (i == 32) check("t6.full32",  {63'd0, full_b},  64'd1);
        end
        check("t6.count32", {58'd0, count_b}, 64'd32);
        for (int i = 1; i <= 32; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 24'd0);
            check("t6.pdo", {56'd0, pdo_b}, 64'(i));
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'd0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
